systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Upstream staging stage for the `systolic` matrix array. It accepts one column of matrix A and one row of matrix B per handshake beat into an internal operand buffer. It then drives the array's `input_left` / `input_top` buses with the diagonally skewed wavefronts the array requires, and zero-fills lanes outside their window. After the operands have drained through the array it reports completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `ARRAY_SIZE`, default 4: array dimension N; number of lanes and number of load beats.
- `DATA_WIDTH`, default 4: operand width per lane.
- `DRAIN_CYCLES`, default 5 (ARRAY_SIZE+1): zero cycles after the last wavefront, before `done`.

Ports:
- `clk`, input, 1: clock; all state is updated on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `load_valid`, input, 1: an operand beat is offered.
- `load_ready`, output, 1: the feeder accepts a beat; high only in IDLE and LOAD.
- `load_a`, input, ARRAY_SIZE*DATA_WIDTH: column k of A; lane i = A[i][k].
- `load_b`, input, ARRAY_SIZE*DATA_WIDTH: row k of B; lane j = B[k][j].
- `left_out`, output, ARRAY_SIZE*DATA_WIDTH: registered; connects to the array's `input_left`.
- `top_out`, output, ARRAY_SIZE*DATA_WIDTH: registered; connects to the array's `input_top`.
- `busy`, output, 1: high in LOAD, FEED, DRAIN and DONE.
- `done`, output, 1: one-cycle pulse in the DONE state.

## Operation
- States: IDLE, LOAD, FEED, DRAIN, DONE. A single counter `cnt` is reused in every state.
- IDLE:
  - `load_ready`=1.
  - A handshake (`load_valid` && `load_ready`) stores beat 0, then → LOAD with `cnt`=1.
  - If N=1, go directly to FEED.
- LOAD:
  - Each handshake stores beat `cnt` into `a_buf[cnt]` / `b_buf[cnt]`, then `cnt`++.
  - The handshake on beat N-1 → FEED with `cnt`=0.
  - Cycles with no handshake leave the state unchanged; there is no timeout.
- FEED (wavefront t = `cnt`, from 0 to 2N-2):
  - `left_out` lane i = `a_buf[t-i][i]` if 0 ≤ t-i < N, else 0.
  - `top_out` lane j = `b_buf[t-j][j]` if 0 ≤ t-j < N, else 0.
  - After t = 2N-2 → DRAIN with `cnt`=0.
- DRAIN:
  - Both output buses are all zeros.
  - After DRAIN_CYCLES cycles → DONE.
- DONE:
  - `done`=1 for exactly one cycle; outputs are zero.
  - → IDLE.
- Outside LOAD handshakes, `load_valid` is ignored. Beats offered while `load_ready`=0 are not consumed.
- Buffer contents persist until overwritten. The buffer is cleared by reset.
- Data is forwarded unmodified; there is no arithmetic. The window test uses a signed comparison of the lane index against `cnt`.

## Timing
- Reset values:
  - State IDLE, `cnt`=0.
  - `left_out` and `top_out` all zeros.
  - `load_ready`=1, `busy`=0, `done`=0.
  - Buffer all zeros.
- Assertion of `reset` takes effect immediately. Reset asserted mid-operation aborts the transfer: the outputs go to zero and no `done` is issued.
- The first wavefront (t=0) is visible in the cycle after the handshake of beat N-1.
- Wavefront t is stable for exactly one cycle. Wavefronts are consecutive, with no gaps.
- `done` is asserted (2N-1) + DRAIN_CYCLES cycles after the first wavefront cycle.
- Total occupancy from the first handshake to the IDLE return, with no load stalls: N + (2N-1) + DRAIN_CYCLES + 1 cycles.
- `load_ready` is combinational from the state and is high in the IDLE cycle that follows DONE. A new transfer can therefore start immediately (back-to-back).

## Configuration
- Macro: `SYSTOLIC_FEEDER_STALL_EN`.
- When defined:
  - An extra input `stall` (1 bit) exists.
  - When `stall`=1 in FEED or DRAIN, `cnt`, the state and both output buses hold their values.
  - `stall` is ignored in IDLE, LOAD and DONE.
- When undefined:
  - The port is absent and the feed runs without interruption.

## Test plan
All scenarios use N=4, DATA_WIDTH=4, DRAIN_CYCLES=5.
- **Reset:** assert `reset` asynchronously between clock edges → outputs zero and `load_ready`=1 before the next edge; `done`=0.
- **Skew, A operand:** load 4 beats with `load_a` lanes all 0x1 and `load_b`=0 → `left_out` lane0 = 1 at t=0..3; lane3 = 0 at t=0..2 and 1 at t=3..6; every lane is 0 at t outside [i, i+3].
- **Skew, B operand:** load beat k with `load_b` lane j = k*4+j (B[k][j]) → `top_out` lane2 at t=2..5 reads 2, 6, 10, 14.
- **Load stall:** deassert `load_valid` for 3 cycles between beats 1 and 2 → no extra beats stored and the wavefronts are unchanged; `done` occurs 3 cycles later than in the unstalled case.
- **Done timing and back-to-back:** `done` is high exactly at first-wavefront + 12 cycles, for one cycle. A second transfer offered in the following cycle is accepted immediately.
- **Abort:** reset asserted during FEED at t=3 → outputs zero at once, no `done`, and a fresh load afterwards completes normally. With `SYSTOLIC_FEEDER_STALL_EN` defined, `stall` held 2 cycles at t=4 → wavefront 4 is held for 3 cycles and `done` is delayed by 2 cycles.

Source files
------------

// File: rtl/systolic_feeder.sv
// Operand staging for the systolic array: buffers N columns of A / rows of B, then emits skewed wavefronts and a done pulse.
// Optional `SYSTOLIC_FEEDER_STALL_EN adds a stall input that freezes the FEED/DRAIN sequence.
module systolic_feeder #(
  parameter int ARRAY_SIZE   = 4,
  parameter int DATA_WIDTH   = 4,
  parameter int DRAIN_CYCLES = ARRAY_SIZE + 1
) (
  input  logic                               clk,
  input  logic                               reset,
`ifdef SYSTOLIC_FEEDER_STALL_EN
  input  logic                               stall,
`endif
  input  logic                               load_valid,
  output logic                               load_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   load_a,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   load_b,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   left_out,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   top_out,
  output logic                               busy,
  output logic                               done
);

  localparam int BW        = ARRAY_SIZE * DATA_WIDTH;
  localparam int FEED_LAST = 2 * ARRAY_SIZE - 2;
  localparam int CNT_MAX   = (FEED_LAST > DRAIN_CYCLES - 1) ? FEED_LAST : DRAIN_CYCLES - 1;
  localparam int CW        = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [ARRAY_SIZE-1:0][BW-1:0] a_buf_q, a_buf_d;
  logic [ARRAY_SIZE-1:0][BW-1:0] b_buf_q, b_buf_d;
  logic [BW-1:0]                left_q, left_d;
  logic [BW-1:0]                top_q, top_d;
  logic                         stall_w;
  logic                         hs;

`ifdef SYSTOLIC_FEEDER_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign load_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign hs         = load_valid && load_ready;
  assign left_out   = left_q;
  assign top_out    = top_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          a_buf_d[0] = load_a;
          b_buf_d[0] = load_b;
          if (ARRAY_SIZE == 1) begin
            state_d = S_FEED;
            cnt_d   = '0;
          end else begin
            state_d = S_LOAD;
            cnt_d   = CW'(1);
          end
        end
      end
      S_LOAD: begin
        if (hs) begin
          for (int k = 0; k < ARRAY_SIZE; k++) begin
            if (cnt_q == CW'(k)) begin
              a_buf_d[k] = load_a;
              b_buf_d[k] = load_b;
            end
          end
          if (cnt_q == CW'(ARRAY_SIZE - 1)) begin
            state_d = S_FEED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FEED: begin
        if (!stall_w) begin
          if (cnt_q == CW'(FEED_LAST)) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!stall_w) begin
          if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the post-edge state and buffer so wavefront 0
  // appears right after the last load beat (including the N=1 bypass case).
  always_comb begin
    left_d = '0;
    top_d  = '0;
    if (state_d == S_FEED) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        for (int k = 0; k < ARRAY_SIZE; k++) begin
          if (int'(cnt_d) - i == k) begin
            left_d[i*DATA_WIDTH +: DATA_WIDTH] = a_buf_d[k][i*DATA_WIDTH +: DATA_WIDTH];
            top_d[i*DATA_WIDTH +: DATA_WIDTH]  = b_buf_d[k][i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_buf_q <= '0;
      b_buf_q <= '0;
      left_q  <= '0;
      top_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_buf_q <= a_buf_d;
      b_buf_q <= b_buf_d;
      left_q  <= left_d;
      top_q   <= top_d;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4, DATA_WIDTH=4, DRAIN_CYCLES=5).
module tb_systolic_feeder;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_a;
  logic [15:0] load_b;
  logic [15:0] left_out;
  logic [15:0] top_out;
  logic        busy;
  logic        done;
`ifdef SYSTOLIC_FEEDER_STALL_EN
  logic        stall;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] va [4];
  logic [15:0] vb [4];
  logic [15:0] el [7];
  logic [15:0] et [7];
  int gap;
  int exp_lat;
  int exp_edges;
  int stall_t;

  systolic_feeder #(
    .ARRAY_SIZE  (4),
    .DATA_WIDTH  (4),
    .DRAIN_CYCLES(5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef SYSTOLIC_FEEDER_STALL_EN
    .stall     (stall),
`endif
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_a    (load_a),
    .load_b    (load_b),
    .left_out  (left_out),
    .top_out   (top_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transfer: load va/vb, compare wavefronts to el/et, time done.
  task automatic xfer(input string nm);
    int edges;
    int cyc;
    edges = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        load_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          step();
          edges++;
        end
      end
      check({nm, "_rdy"}, 32'(load_ready), 32'd1);
      load_valid = 1'b1;
      load_a     = va[k];
      load_b     = vb[k];
      step();
      if (k > 0) edges++;
    end
    load_valid = 1'b0;
    load_a     = 16'h0;
    load_b     = 16'h0;
    check({nm, "_busy"}, 32'(busy), 32'd1);
    check({nm, "_rdy_feed"}, 32'(load_ready), 32'd0);
    for (int t = 0; t < 7; t++) begin
      check($sformatf("%s_left_t%0d", nm, t), 32'(left_out), 32'(el[t]));
      check($sformatf("%s_top_t%0d", nm, t), 32'(top_out), 32'(et[t]));
`ifdef SYSTOLIC_FEEDER_STALL_EN
      if (t == stall_t) begin
        stall = 1'b1;
        for (int s = 0; s < 2; s++) begin
          step();
          edges++;
          check($sformatf("%s_hold%0d", nm, s), 32'(left_out), 32'(el[t]));
        end
        stall = 1'b0;
      end
`endif
      step();
      edges++;
    end
    cyc = 7;
`ifdef SYSTOLIC_FEEDER_STALL_EN
    if (stall_t >= 0) cyc = 9;
`endif
    while (!done && cyc < 40) begin
      check({nm, "_drain_zero"}, 32'(left_out | top_out), 32'd0);
      step();
      cyc++;
      edges++;
    end
    check({nm, "_done_lat"}, 32'(cyc), 32'(exp_lat));
    check({nm, "_occupancy"}, 32'(edges), 32'(exp_edges));
    check({nm, "_done_out0"}, 32'(left_out | top_out), 32'd0);
    // Offered during DONE: must not be consumed as the next beat 0.
    load_valid = 1'b1;
    load_a     = 16'hEEEE;
    load_b     = 16'hEEEE;
    step();
    check({nm, "_done_pulse"}, 32'(done), 32'd0);
    check({nm, "_rdy_idle"}, 32'(load_ready), 32'd1);
    load_valid = 1'b0;
    load_a     = 16'h0;
    load_b     = 16'h0;
  endtask

  task automatic set_skew_a();
    va = '{16'h1111, 16'h1111, 16'h1111, 16'h1111};
    vb = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    el = '{16'h0001, 16'h0011, 16'h0111, 16'h1111, 16'h1110, 16'h1100, 16'h1000};
    et = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  endtask

  task automatic set_skew_b();
    va = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    vb = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    el = '{16'h0001, 16'h0012, 16'h0123, 16'h1234, 16'h2340, 16'h3400, 16'h4000};
    et = '{16'h0000, 16'h0014, 16'h0258, 16'h369C, 16'h7AD0, 16'hBE00, 16'hF000};
  endtask

  initial begin
    int dc;
    reset      = 1'b0;
    load_valid = 1'b0;
    load_a     = 16'h0;
    load_b     = 16'h0;
    gap        = 0;
    stall_t    = -1;
    exp_lat    = 12;
    exp_edges  = 15;
`ifdef SYSTOLIC_FEEDER_STALL_EN
    stall      = 1'b0;
`endif
    #1 reset = 1'b1;
    #2;
    check("rst_left", 32'(left_out), 32'd0);
    check("rst_top", 32'(top_out), 32'd0);
    check("rst_rdy", 32'(load_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    #10 reset = 1'b0;
    step();

    set_skew_a();
    xfer("skewA");

    // Starts in the IDLE cycle right after DONE: back-to-back.
    set_skew_b();
    xfer("skewB");

    gap       = 3;
    exp_edges = 18;
    xfer("ldstall");
    gap       = 0;
    exp_edges = 15;

    // Abort during FEED at t=3.
    for (int k = 0; k < 4; k++) begin
      load_valid = 1'b1;
      load_a     = va[k];
      load_b     = vb[k];
      step();
    end
    load_valid = 1'b0;
    repeat (3) step();
    check("abort_t3", 32'(left_out), 32'h1234);
    #2 reset = 1'b1;
    #1;
    check("abort_left", 32'(left_out), 32'd0);
    check("abort_top", 32'(top_out), 32'd0);
    check("abort_rdy", 32'(load_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    #2 reset = 1'b0;
    dc = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done) dc++;
    end
    check("abort_nodone", 32'(dc), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    set_skew_a();
    xfer("fresh");

`ifdef SYSTOLIC_FEEDER_STALL_EN
    set_skew_b();
    stall_t   = 4;
    exp_lat   = 14;
    exp_edges = 17;
    xfer("feedstall");
    stall_t   = -1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
